// File: rtl/fpu_div_issue.sv
`default_nettype none
// ============================================================================
// Module      : fpu_div_issue
// Description : Front end for an iterative FP divider. It screens out special
//               operands, launches the divider, waits for it with a timeout
//               and returns the quotient through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_div_issue #(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_fmt,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    output logic [63:0] div_a,
    output logic [63:0] div_b,
    output logic        div_go,
    input  logic        div_done,
    input  logic [63:0] div_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [3:0]  out_flags
);

    localparam int                 c_CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT);
    localparam logic [63:0]        c_QNAN64    = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0]        c_QNAN32    = 64'h0000_0000_7FC0_0000;
    localparam logic [3:0]         c_FLG_NONE  = 4'b0000;
    localparam logic [3:0]         c_FLG_TMO   = 4'b1000;
    localparam logic [3:0]         c_FLG_SPEC  = 4'b0100;
    localparam logic [3:0]         c_FLG_DIVZ  = 4'b0110;
    localparam logic [3:0]         c_FLG_INV   = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_fmt;
    logic [63:0]          r_a;
    logic [63:0]          r_b;
    logic [63:0]          r_result;
    logic [3:0]           r_flags;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [63:0]          w_a;
    logic [63:0]          w_b;
    logic                 w_a_exp_max;
    logic                 w_a_exp_zero;
    logic                 w_a_man_zero;
    logic                 w_b_exp_max;
    logic                 w_b_exp_zero;
    logic                 w_b_man_zero;
    logic                 w_sign;
    logic                 w_a_nan;
    logic                 w_b_nan;
    logic                 w_a_inf;
    logic                 w_b_inf;
    logic                 w_a_zero;
    logic                 w_b_zero;
    logic                 w_special;
    logic [63:0]          w_qnan;
    logic [63:0]          w_inf;
    logic [63:0]          w_zero;
    logic [63:0]          w_spec_result;
    logic [3:0]           w_spec_flags;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic                 w_timeout;

    // Field decode of the incoming operands; binary32 lives in the low word.
    always_comb begin
        if (in_fmt) begin
            w_a          = {32'd0, in_a[31:0]};
            w_b          = {32'd0, in_b[31:0]};
            w_a_exp_max  = &in_a[30:23];
            w_a_exp_zero = ~|in_a[30:23];
            w_a_man_zero = ~|in_a[22:0];
            w_b_exp_max  = &in_b[30:23];
            w_b_exp_zero = ~|in_b[30:23];
            w_b_man_zero = ~|in_b[22:0];
            w_sign       = in_a[31] ^ in_b[31];
        end else begin
            w_a          = in_a;
            w_b          = in_b;
            w_a_exp_max  = &in_a[62:52];
            w_a_exp_zero = ~|in_a[62:52];
            w_a_man_zero = ~|in_a[51:0];
            w_b_exp_max  = &in_b[62:52];
            w_b_exp_zero = ~|in_b[62:52];
            w_b_man_zero = ~|in_b[51:0];
            w_sign       = in_a[63] ^ in_b[63];
        end
    end

    assign w_a_nan   = w_a_exp_max & ~w_a_man_zero;
    assign w_b_nan   = w_b_exp_max & ~w_b_man_zero;
    assign w_a_inf   = w_a_exp_max & w_a_man_zero;
    assign w_b_inf   = w_b_exp_max & w_b_man_zero;
    assign w_a_zero  = w_a_exp_zero & w_a_man_zero;
    assign w_b_zero  = w_b_exp_zero & w_b_man_zero;
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;

    assign w_qnan = in_fmt ? c_QNAN32 : c_QNAN64;
    assign w_inf  = in_fmt ? {32'd0, w_sign, 8'hFF, 23'd0} : {w_sign, 11'h7FF, 52'd0};
    assign w_zero = in_fmt ? {32'd0, w_sign, 31'd0}        : {w_sign, 63'd0};

    // Special-operand priority: NaN, invalid, divide-by-zero, Inf, zero.
    always_comb begin
        w_spec_result = w_zero;
        w_spec_flags  = c_FLG_SPEC;
        if (w_a_nan | w_b_nan) begin
            w_spec_result = w_qnan;
        end else if ((w_a_inf & w_b_inf) | (w_a_zero & w_b_zero)) begin
            w_spec_result = w_qnan;
            w_spec_flags  = c_FLG_INV;
        end else if (w_b_zero) begin
            w_spec_result = w_inf;
            w_spec_flags  = c_FLG_DIVZ;
        end else if (w_a_inf) begin
            w_spec_result = w_inf;
        end
    end

    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    assign w_timeout = (w_cnt_inc == c_CNT_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        div_go      = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    w_state_nxt = w_special ? S_OUT : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                div_go      = ~rst;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (div_done || w_timeout) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = ~rst;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_fmt    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_fmt    <= in_fmt;
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_cnt    <= '0;
                        r_result <= w_spec_result;
                        r_flags  <= w_spec_flags;
                    end
                end
                S_RUN: begin
                    // A completion in the timeout cycle still wins.
                    if (div_done) begin
                        r_result <= r_fmt ? {32'd0, div_result[31:0]} : div_result;
                        r_flags  <= c_FLG_NONE;
                    end else if (w_timeout) begin
                        r_result <= r_fmt ? c_QNAN32 : c_QNAN64;
                        r_flags  <= c_FLG_TMO;
                    end
                    r_cnt <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    // Registers lag reset by one edge, so outputs are also forced low by rst.
    assign div_a      = rst ? 64'd0 : r_a;
    assign div_b      = rst ? 64'd0 : r_b;
    assign out_result = rst ? 64'd0 : r_result;
    assign out_flags  = rst ? 4'd0  : r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fpu_div_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_div_issue
// Description : Randomised scoreboard bench for fpu_div_issue with a
//               behavioural divider model and a reference result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_div_issue;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_fmt;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [63:0] div_a;
    logic [63:0] div_b;
    logic        div_go;
    logic        div_done;
    logic [63:0] div_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [3:0]  out_flags;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [67:0] sb[$];
    int          nxt_lat  = -1;
    logic [63:0] nxt_q    = '0;
    logic [63:0] exp_da   = '0;
    logic [63:0] exp_db   = '0;
    bit          bp_force = 1'b0;
    int          go_count = 0;

    fpu_div_issue #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_a       (in_a),
        .in_b       (in_b),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_go     (div_go),
        .div_done   (div_done),
        .div_result (div_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // IEEE-754 division outcome from field values; lat is divider latency
    // after launch (-1 = never answers).
    function automatic logic [67:0] ref_div(input logic fmt, input logic [63:0] a,
                                            input logic [63:0] b, input int lat,
                                            input logic [63:0] q);
        longint unsigned ea, eb, ma, mb, emax;
        logic        sgn;
        logic [63:0] qnan, inf, zero;
        bit          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        if (fmt) begin
            ea = (a >> 23) & 64'hFF;  eb = (b >> 23) & 64'hFF;
            ma = a & 64'h7F_FFFF;     mb = b & 64'h7F_FFFF;
            emax = 255;
            sgn  = a[31] ^ b[31];
            qnan = 64'h7FC0_0000;
            inf  = sgn ? 64'hFF80_0000 : 64'h7F80_0000;
            zero = sgn ? 64'h8000_0000 : 64'h0;
        end else begin
            ea = (a >> 52) & 64'h7FF; eb = (b >> 52) & 64'h7FF;
            ma = a & 64'h000F_FFFF_FFFF_FFFF;
            mb = b & 64'h000F_FFFF_FFFF_FFFF;
            emax = 2047;
            sgn  = a[63] ^ b[63];
            qnan = 64'h7FF8_0000_0000_0000;
            inf  = sgn ? 64'hFFF0_0000_0000_0000 : 64'h7FF0_0000_0000_0000;
            zero = sgn ? 64'h8000_0000_0000_0000 : 64'h0;
        end
        a_nan  = (ea == emax) && (ma != 0);  b_nan  = (eb == emax) && (mb != 0);
        a_inf  = (ea == emax) && (ma == 0);  b_inf  = (eb == emax) && (mb == 0);
        a_zero = (ea == 0) && (ma == 0);     b_zero = (eb == 0) && (mb == 0);
        if (a_nan || b_nan)                            return {4'b0100, qnan};
        if ((a_inf && b_inf) || (a_zero && b_zero))    return {4'b0101, qnan};
        if (b_zero)                                    return {4'b0110, inf};
        if (a_inf)                                     return {4'b0100, inf};
        if (b_inf || a_zero)                           return {4'b0100, zero};
        if (lat >= 1 && lat <= TIMEOUT)                return {4'b0000, fmt ? (q & 64'hFFFF_FFFF) : q};
        return {4'b1000, qnan};
    endfunction

    function automatic logic [63:0] gen_op(input logic fmt, input bit normal_only);
        logic [63:0] v;
        int          k;
        v = {$urandom, $urandom};
        k = normal_only ? 9 : int'($urandom_range(0, 11));
        if (fmt) begin
            case (k)
                0:       v[30:0] = 31'd0;
                1:       v[30:0] = {8'hFF, 23'd0};
                2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
                3:       v[30:23] = 8'h00;
                default: v[30:23] = 8'($urandom_range(1, 254));
            endcase
        end else begin
            case (k)
                0:       v[62:0] = 63'd0;
                1:       v[62:0] = {11'h7FF, 52'd0};
                2:       begin v[62:52] = 11'h7FF; v[0] = 1'b1; end
                3:       v[62:52] = 11'h000;
                default: v[62:52] = 11'($urandom_range(1, 2046));
            endcase
        end
        return v;
    endfunction

    task automatic issue(input logic fmt, input logic [63:0] a, input logic [63:0] b,
                         input int lat, input logic [63:0] q, input bit expect_out);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        in_fmt = fmt; in_a = a; in_b = b; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 500) begin
                fail_bound("request accept");
                break;
            end
        end
        nxt_lat = lat;
        nxt_q   = q;
        exp_da  = fmt ? {32'd0, a[31:0]} : a;
        exp_db  = fmt ? {32'd0, b[31:0]} : b;
        if (expect_out) sb.push_back(ref_div(fmt, a, b, lat, q));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) fail_bound("scoreboard drain");
    endtask

    // Monitor: every accepted result is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        logic [67:0] e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected output: result %h flags %b, none expected", out_result, out_flags);
            end else begin
                e = sb.pop_front();
                chk("out_result", out_result, e[63:0]);
                chk("out_flags", 64'(out_flags), 64'(e[67:64]));
            end
        end
    end

    // Divider model: answers nxt_lat cycles after the launch pulse.
    initial begin : div_model
        int          cnt;
        int          lat_cur;
        logic [63:0] q;
        bit          abandoned;
        cnt = -1; lat_cur = -1; q = '0; abandoned = 1'b0;
        div_done = 1'b0; div_result = '0;
        forever begin
            @(negedge clk);
            div_done   = 1'b0;
            div_result = {$urandom, $urandom};
            if (rst) abandoned = 1'b1;
            if (div_go) begin
                go_count++;
                chk("div_a at launch", div_a, exp_da);
                chk("div_b at launch", div_b, exp_db);
                cnt = nxt_lat; lat_cur = nxt_lat; q = nxt_q; abandoned = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    div_done   = 1'b1;
                    div_result = q;
                    cnt        = -1;
                    if (!abandoned && lat_cur <= TIMEOUT) begin
                        chk("div_a held in run", div_a, exp_da);
                        chk("div_b held in run", div_b, exp_db);
                    end
                end
            end
        end
    end

    initial begin : ready_driver
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!bp_force) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          g;
        int          go0;
        bit          seen;
        logic [63:0] hold_r;
        logic [3:0]  hold_f;
        logic        f;
        int          lat;

        rst = 1'b1; in_valid = 1'b0; in_fmt = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset div_go/out_valid", 64'({div_go, out_valid}), 64'd0);
        chk("reset out_result", out_result, 64'd0);
        chk("reset out_flags", 64'(out_flags), 64'd0);
        chk("reset div_a", div_a, 64'd0);
        chk("reset div_b", div_b, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", 64'(in_ready), 64'd1);

        // Normal binary64 6/2, divider answers 14 cycles after launch.
        go0 = go_count;
        issue(1'b0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 14, 64'h4008_0000_0000_0000, 1'b1);
        drain();
        chk("div_go pulses for normal op", 64'(go_count - go0), 64'd1);

        // Binary32 1 / -0.
        go0 = go_count;
        issue(1'b1, 64'h3F80_0000, 64'h8000_0000, 5, 64'h0, 1'b1);
        @(negedge clk);
        chk("special out_valid latency", 64'(out_valid), 64'd1);
        drain();
        chk("no div_go for special", 64'(go_count - go0), 64'd0);

        // Binary32 0/0.
        issue(1'b1, 64'h0, 64'h0, 5, 64'h0, 1'b1);
        drain();

        // Backpressure on a normal op.
        @(posedge clk); #2;
        bp_force = 1'b1; out_ready = 1'b0;
        issue(1'b0, gen_op(1'b0, 1'b1), gen_op(1'b0, 1'b1), 6, {$urandom, $urandom}, 1'b1);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!out_valid) fail_bound("backpressure out_valid");
        hold_r = out_result;
        hold_f = out_flags;
        repeat (10) begin
            @(negedge clk);
            chk("bp valid/in_ready", 64'({out_valid, in_ready}), 64'(2'b10));
            chk("bp result stable", out_result, hold_r);
            chk("bp flags stable", 64'(out_flags), 64'(hold_f));
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        @(negedge clk);
        chk("no accept in handshake cycle", 64'(in_ready), 64'd0);
        @(posedge clk); #2;
        bp_force = 1'b0;
        @(negedge clk);
        chk("idle after handshake", 64'({in_ready, out_valid}), 64'(2'b10));
        drain();

        // Timeouts: never, same cycle as timeout, one cycle late.
        issue(1'b0, gen_op(1'b0, 1'b1), gen_op(1'b0, 1'b1), -1, {$urandom, $urandom}, 1'b1);
        issue(1'b1, gen_op(1'b1, 1'b1), gen_op(1'b1, 1'b1), TIMEOUT, {$urandom, $urandom}, 1'b1);
        issue(1'b0, gen_op(1'b0, 1'b1), gen_op(1'b0, 1'b1), TIMEOUT, {$urandom, $urandom}, 1'b1);
        issue(1'b0, gen_op(1'b0, 1'b1), gen_op(1'b0, 1'b1), TIMEOUT + 1, {$urandom, $urandom}, 1'b1);
        drain();

        // Reset while the divider is running; its late answer must vanish.
        issue(1'b0, gen_op(1'b0, 1'b1), gen_op(1'b0, 1'b1), 12, {$urandom, $urandom}, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after mid-run reset", 64'(in_ready), 64'd1);
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("no output from abandoned op", 64'(seen), 64'd0);
        issue(1'b0, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 9, 64'h4008_0000_0000_0000, 1'b1);
        drain();

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            f = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       lat = -1;
                1:       lat = TIMEOUT;
                2:       lat = TIMEOUT + 1;
                default: lat = int'($urandom_range(1, 20));
            endcase
            issue(f, gen_op(f, 1'b0), gen_op(f, 1'b0), lat, {$urandom, $urandom}, 1'b1);
        end
        drain();
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
